pad_input_reader: RTL and testbench

- Drives the serial game-pad interface (latch, clock, data) and decodes the shifted-in button frame.
- Produces the movement strobes L, R, U, D, the current-direction code cd, and action buttons for the Bomberman movement/animation logic.
- Owns cd, so that only one movement direction is asserted at any time.
- Sits between the board pad connector and the player, bomb and game-state modules; one instance per pad.

---
 rtl/pad_input_reader.sv | 173 +++++++++++++++++
 tb/tb_pad_input_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_input_reader.sv
// pad_input_reader: polls a serial game pad and decodes buttons/direction.
// Define PAD_SNES_EN for the 16-bit SNES frame with controller ID check.
module pad_input_reader #(
  parameter int CLK_DIV     = 600,
  parameter int POLL_PERIOD = 1666666
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic       L,
  output logic       R,
  output logic       U,
  output logic       D,
  output logic [1:0] cd,
  output logic       btn_a,
  output logic       btn_b,
  output logic       btn_start,
  output logic       btn_select,
  output logic       frame_valid
);

`ifdef PAD_SNES_EN
  localparam int NBITS = 16;
`else
  localparam int NBITS = 8;
`endif
  localparam int PW = $clog2(POLL_PERIOD);
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(NBITS);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [DW-1:0] LAT_LAST  = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);

  typedef enum logic [2:0] {
    IDLE, LATCH, WAIT0, CLK_HI, CLK_LO, UPDATE
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   poll_q;
  logic [DW-1:0]   div_q;
  logic [BW-1:0]   bit_q;
  logic [NBITS-1:0] sh_q;
  logic            latch_q, pclk_q, fv_q;
  logic [3:0]      lrud_q;
  logic [1:0]      cd_q;
  logic [3:0]      btn_q;
  logic            tick;

  // resolved direction for the frame currently in sh_q
  logic [3:0] dirs;
  logic       dir_any;
  logic [1:0] cd_d;
  logic [3:0] lrud_d;
  logic [3:0] btn_d;
  logic       id_ok;

  assign tick = (poll_q == POLL_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) poll_q <= '0;
    else if (tick) poll_q <= '0;
    else poll_q <= poll_q + 1'b1;
  end

  always_comb begin
    dirs    = {sh_q[6], sh_q[5], sh_q[7], sh_q[4]};
    dir_any = |dirs;
    cd_d    = cd_q;
    if (dir_any && !dirs[cd_q]) begin
      if (dirs[0])      cd_d = 2'd0;
      else if (dirs[1]) cd_d = 2'd1;
      else if (dirs[2]) cd_d = 2'd2;
      else              cd_d = 2'd3;
    end
    lrud_d = '0;
    if (dir_any)
      lrud_d = {cd_d == 2'd3, cd_d == 2'd1,
                cd_d == 2'd0, cd_d == 2'd2};
`ifdef PAD_SNES_EN
    id_ok = (sh_q[15:12] == 4'b0000);
    btn_d = {sh_q[8], sh_q[0], sh_q[3], sh_q[2]};
`else
    id_ok = 1'b1;
    btn_d = {sh_q[0], sh_q[1], sh_q[3], sh_q[2]};
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      latch_q <= 1'b0;
      pclk_q  <= 1'b0;
      fv_q    <= 1'b0;
      lrud_q  <= '0;
      cd_q    <= 2'b10;
      btn_q   <= '0;
    end else begin
      fv_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (tick) begin
            state_q <= LATCH;
            latch_q <= 1'b1;
            div_q   <= '0;
          end
        end
        LATCH: begin
          if (div_q == LAT_LAST) begin
            state_q <= WAIT0;
            latch_q <= 1'b0;
            div_q   <= '0;
          end else div_q <= div_q + 1'b1;
        end
        WAIT0: begin
          if (div_q == DIV_LAST) begin
            sh_q[0] <= ~pad_data;
            bit_q   <= BW'(1);
            state_q <= CLK_HI;
            pclk_q  <= 1'b1;
            div_q   <= '0;
          end else div_q <= div_q + 1'b1;
        end
        CLK_HI: begin
          if (div_q == DIV_LAST) begin
            state_q <= CLK_LO;
            pclk_q  <= 1'b0;
            div_q   <= '0;
          end else div_q <= div_q + 1'b1;
        end
        CLK_LO: begin
          if (div_q == DIV_LAST) begin
            sh_q[bit_q] <= ~pad_data;
            div_q       <= '0;
            if (bit_q == BIT_LAST) begin
              state_q <= UPDATE;
            end else begin
              state_q <= CLK_HI;
              pclk_q  <= 1'b1;
              bit_q   <= bit_q + 1'b1;
            end
          end else div_q <= div_q + 1'b1;
        end
        UPDATE: begin
          state_q <= IDLE;
          if (id_ok) begin
            cd_q   <= cd_d;
            lrud_q <= lrud_d;
            btn_q  <= btn_d;
            fv_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pad_latch   = latch_q;
  assign pad_clk     = pclk_q;
  assign {L, R, U, D} = lrud_q;
  assign cd          = cd_q;
  assign btn_a       = btn_q[3];
  assign btn_b       = btn_q[2];
  assign btn_start   = btn_q[1];
  assign btn_select  = btn_q[0];
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_pad_input_reader.sv
// tb_pad_input_reader: random pad frames vs. behavioural model,
// scoreboarded on frame_valid, plus latch/clock timing checks.
module tb_pad_input_reader;
  localparam int CLK_DIV = 4;
  localparam int POLL    = 400;
`ifdef PAD_SNES_EN
  localparam int NB    = 16;
  localparam int A_BIT = 8;
`else
  localparam int NB    = 8;
  localparam int A_BIT = 0;
`endif
  localparam int FRAME_CYC = (3 + 2 * NB) * CLK_DIV + 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pad_data;
  logic pad_latch, pad_clk, L, R, U, D;
  logic btn_a, btn_b, btn_start, btn_select, frame_valid;
  logic [1:0] cd;

  int tests = 0;
  int fails = 0;
  int vcnt  = 0;

  // pad model: parallel load on latch rise, shift on clock rise
  logic [NB-1:0] pad_n   = '1;
  logic [NB-1:0] pad_lat = '1;
  int idx = 0;
  assign pad_data = (idx < NB) ? pad_lat[idx] : 1'b1;
  always @(posedge pad_latch) begin
    pad_lat = pad_n;
    idx = 0;
  end
  always @(posedge pad_clk) idx = idx + 1;

  // reference model state
  logic [1:0] m_cd   = 2'b10;
  logic [3:0] m_lrud = '0;
  logic [3:0] m_btn  = '0;
  logic [9:0] sbq[$];

  logic [9:0] dut_vec;
  assign dut_vec = {cd, L, R, U, D, btn_a, btn_b, btn_start, btn_select};

  pad_input_reader #(.CLK_DIV(CLK_DIV), .POLL_PERIOD(POLL)) dut (
    .clk(clk), .reset(reset), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk),
    .L(L), .R(R), .U(U), .D(D), .cd(cd),
    .btn_a(btn_a), .btn_b(btn_b),
    .btn_start(btn_start), .btn_select(btn_select),
    .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] mvec();
    return {m_cd, m_lrud, m_btn};
  endfunction

  task automatic model_reset();
    m_cd = 2'b10;
    m_lrud = '0;
    m_btn = '0;
  endtask

  // apply the direction rules to pressed set p
  task automatic model_apply(input logic [NB-1:0] p, output bit valid);
    bit dp[4];
    valid = 1'b1;
`ifdef PAD_SNES_EN
    if (p[15:12] != 4'b0000) begin
      valid = 1'b0;
      return;
    end
    m_btn = {p[8], p[0], p[3], p[2]};
`else
    m_btn = {p[0], p[1], p[3], p[2]};
`endif
    dp[0] = p[4];
    dp[1] = p[7];
    dp[2] = p[5];
    dp[3] = p[6];
    if (!(dp[0] || dp[1] || dp[2] || dp[3])) begin
      m_lrud = '0;
    end else begin
      if (!dp[m_cd])
        for (int i = 3; i >= 0; i--)
          if (dp[i]) m_cd = 2'(i);
      m_lrud = {m_cd == 2'd3, m_cd == 2'd1, m_cd == 2'd0, m_cd == 2'd2};
    end
  endtask

  always @(negedge clk) begin
    if (!reset && frame_valid === 1'b1) begin
      vcnt++;
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_frame_valid: outputs %0h, none expected",
                 dut_vec);
      end else begin
        chk("frame_outputs", {22'd0, dut_vec}, {22'd0, sbq.pop_front()});
      end
    end
  end

  task automatic wait_latch(output int n);
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      if (pad_latch === 1'b1) return;
    end
    tests++;
    fails++;
    $display("FAIL latch_timeout: waited %0d cycles, required < 1000", n);
  endtask

  task automatic release_and_measure();
    int n, lw, hi, pulses, minw, maxw, lat2;
    @(negedge clk);
    reset = 1'b0;
    wait_latch(n);
    chk("first_latch_delay", n, POLL);
    lw = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pad_latch) lw++;
      else break;
    end
    chk("latch_width", lw, 2 * CLK_DIV);
    hi = 0; pulses = 0; minw = 999; maxw = 0; lat2 = 0;
    for (int i = 0; i < (3 + 2 * NB) * CLK_DIV; i++) begin
      @(negedge clk);
      if (pad_latch) lat2++;
      if (pad_clk) hi++;
      else if (hi != 0) begin
        pulses++;
        if (hi < minw) minw = hi;
        if (hi > maxw) maxw = hi;
        hi = 0;
      end
    end
    chk("clk_pulses", pulses, NB - 1);
    chk("clk_min_width", minw, CLK_DIV);
    chk("clk_max_width", maxw, CLK_DIV);
    chk("extra_latch", lat2, 0);
  endtask

  task automatic run_frame(input logic [NB-1:0] p);
    bit v;
    int n, v0;
    pad_n = ~p;
    model_apply(p, v);
    if (v) sbq.push_back(mvec());
    v0 = vcnt;
    wait_latch(n);
    repeat (FRAME_CYC) @(negedge clk);
    chk("valid_count", vcnt - v0, {31'd0, v});
    chk("held_outputs", {22'd0, dut_vec}, {22'd0, mvec()});
    chk("queue_empty", sbq.size(), 0);
  endtask

  initial begin
    logic [NB-1:0] p;
    int v0, rises, n;
    logic prev;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {22'd0, dut_vec}, 32'h200);
    chk("reset_latch", {31'd0, pad_latch}, 0);
    chk("reset_pad_clk", {31'd0, pad_clk}, 0);
    chk("reset_frame_valid", {31'd0, frame_valid}, 0);

    // first frame: Up, with latch/clock timing measured
    p = '0;
    p[4] = 1'b1;
    pad_n = ~p;
    begin
      bit v;
      model_apply(p, v);
      sbq.push_back(mvec());
    end
    v0 = vcnt;
    release_and_measure();
    repeat (4) @(negedge clk);
    chk("first_valid_count", vcnt - v0, 1);
    chk("first_outputs", {22'd0, dut_vec}, {22'd0, mvec()});

    p = '0; p[7] = 1'b1;             run_frame(p);
    p = '0; p[7] = 1'b1; p[4] = 1'b1; run_frame(p);
    p = '0; p[4] = 1'b1;             run_frame(p);
    p = '0; p[6] = 1'b1;             run_frame(p);
    p = '0;                          run_frame(p);
    p = '0; p[A_BIT] = 1'b1; p[3] = 1'b1; run_frame(p);
    p = '0; p[4] = 1'b1; p[5] = 1'b1; run_frame(p);

`ifdef PAD_SNES_EN
    p = 16'hF100; run_frame(p);
    p = 16'h0100; run_frame(p);
`endif

    for (int i = 0; i < 16; i++) begin
      p = NB'($urandom);
`ifdef PAD_SNES_EN
      if ($urandom_range(3) != 0) p[15:12] = 4'b0000;
`endif
      run_frame(p);
    end

    // reset during the third pad_clk high phase
    p = '0; p[7] = 1'b1;
    pad_n = ~p;
    wait_latch(n);
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 200 && rises < 3; i++) begin
      @(negedge clk);
      if (pad_clk && !prev) rises++;
      prev = pad_clk;
    end
    chk("third_pulse_seen", rises, 3);
    reset = 1'b1;
    #1;
    chk("midreset_pad_clk", {31'd0, pad_clk}, 0);
    chk("midreset_outputs", {22'd0, dut_vec}, 32'h200);
    chk("midreset_latch", {31'd0, pad_latch}, 0);
    chk("midreset_fv", {31'd0, frame_valid}, 0);
    model_reset();
    repeat (3) @(negedge clk);
    p = '0; p[5] = 1'b1; p[1] = 1'b1;
    pad_n = ~p;
    begin
      bit v;
      model_apply(p, v);
      sbq.push_back(mvec());
    end
    v0 = vcnt;
    release_and_measure();
    repeat (4) @(negedge clk);
    chk("post_reset_valid_count", vcnt - v0, 1);
    chk("post_reset_outputs", {22'd0, dut_vec}, {22'd0, mvec()});
    chk("final_queue_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
